// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the upstream issue logic, the ALU result
// stage and the downstream consumer.
interface alu_result_stage_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] funct;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shifter_out;
  logic [WIDTH-1:0]   hi_in;
  logic [WIDTH-1:0]   lo_in;
  logic               hilo_busy;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic [FUNCT_W-1:0] out_funct;
  logic               illegal;

  modport master (
    output in_valid, funct, alu_out, shifter_out, hi_in, lo_in, hilo_busy, out_ready,
    input  in_ready, out_valid, data_out, out_funct, illegal
  );

  modport slave (
    input  in_valid, funct, alu_out, shifter_out, hi_in, lo_in, hilo_busy, out_ready,
    output in_ready, out_valid, data_out, out_funct, illegal
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered funct-decoded result select with a valid/ready output and a
// hold state for MFHI/MFLO issued while the multiply/divide unit is busy.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_EMPTY   | no result held; ready for a new op
//   S_FULL    | result valid on data_out; new op accepted only on out_ready
//   S_WAIT    | MFHI/MFLO accepted, waiting for hilo_busy to drop
module alu_result_stage #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_SRA  = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] F_MFHI = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO = FUNCT_W'(6'b010010);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_data;
  logic [FUNCT_W-1:0] r_funct;
  logic               r_illegal;

  logic [WIDTH-1:0]   w_sel;
  logic               w_illegal;
  logic               w_is_hilo;
  logic               w_in_ready;
  logic               w_accept;

  always_comb begin
    w_sel     = '0;
    w_illegal = 1'b0;
    w_is_hilo = 1'b0;
    case (bus.funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: w_sel = bus.alu_out;
      F_SLL, F_SRL, F_SRA:              w_sel = bus.shifter_out;
      F_MFHI: begin
        w_sel     = bus.hi_in;
        w_is_hilo = 1'b1;
      end
      F_MFLO: begin
        w_sel     = bus.lo_in;
        w_is_hilo = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Ready depends only on state and out_ready, never on in_valid/funct.
  assign w_in_ready = (r_state == S_EMPTY) || ((r_state == S_FULL) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_data    <= '0;
      r_funct   <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY, S_FULL: begin
          if (w_accept) begin
            r_funct <= bus.funct;
            if (w_is_hilo && bus.hilo_busy) begin
              r_state   <= S_WAIT;
              r_illegal <= 1'b0;
            end else begin
              r_state   <= S_FULL;
              r_data    <= w_sel;
              r_illegal <= w_illegal;
            end
          end else if (r_state == S_FULL && bus.out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        S_WAIT: begin
          // HI/LO are taken in the same cycle busy is seen low.
          if (!bus.hilo_busy) begin
            r_data  <= (r_funct == F_MFHI) ? bus.hi_in : bus.lo_in;
            r_state <= S_FULL;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_FULL);
  assign bus.data_out  = r_data;
  assign bus.out_funct = r_funct;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed test-plan steps followed
// by random traffic, all compared against a one-slot reference model.
module tb_alu_result_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(32), .FUNCT_W(6)) ifc ();
  alu_result_stage_if #(.WIDTH(64), .FUNCT_W(6)) ifc64 ();

  alu_result_stage #(.WIDTH(32), .FUNCT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  alu_result_stage #(.WIDTH(64), .FUNCT_W(6)) dut64 (.clk(clk), .rst_n(rst_n), .bus(ifc64));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: at most one finished result, or one HI/LO op waiting.
  bit          m_full = 0;
  bit          m_wait = 0;
  logic [31:0] m_data = '0;
  logic [5:0]  m_funct = '0;
  logic        m_ill = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec decode table: {illegal, result}.
  function automatic logic [32:0] ref_sel(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] s, input logic [31:0] h,
                                          input logic [31:0] l);
    case (f)
      6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010: return {1'b0, a};
      6'b000000, 6'b000010, 6'b000011:                       return {1'b0, s};
      6'b010000: return {1'b0, h};
      6'b010010: return {1'b0, l};
      default:   return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic bit is_hilo(input logic [5:0] f);
    return (f == 6'b010000) || (f == 6'b010010);
  endfunction

  task automatic model_reset();
    m_full = 0; m_wait = 0; m_data = '0; m_funct = '0; m_ill = 0;
  endtask

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic cycle();
    logic        exp_rdy;
    logic [32:0] r;
    #1;
    exp_rdy = !m_wait && (!m_full || ifc.out_ready);
    chk("in_ready", {63'b0, ifc.in_ready}, {63'b0, exp_rdy});
    if (m_wait) begin
      if (!ifc.hilo_busy) begin
        m_data = (m_funct == 6'b010000) ? ifc.hi_in : ifc.lo_in;
        m_full = 1; m_wait = 0; m_ill = 0;
      end
    end else begin
      if (m_full && ifc.out_ready) m_full = 0;
      if (ifc.in_valid && exp_rdy) begin
        m_funct = ifc.funct;
        if (is_hilo(ifc.funct) && ifc.hilo_busy) begin
          m_wait = 1; m_ill = 0;
        end else begin
          r = ref_sel(ifc.funct, ifc.alu_out, ifc.shifter_out, ifc.hi_in, ifc.lo_in);
          m_full = 1; m_data = r[31:0]; m_ill = r[32];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'b0, ifc.out_valid}, {63'b0, m_full});
    if (m_full) begin
      chk("data_out", {32'b0, ifc.data_out}, {32'b0, m_data});
      chk("illegal", {63'b0, ifc.illegal}, {63'b0, m_ill});
    end
    if (m_full || m_wait) chk("out_funct", {58'b0, ifc.out_funct}, {58'b0, m_funct});
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] s, input logic [31:0] h, input logic [31:0] l,
                       input logic busy, input logic ordy);
    ifc.in_valid = v; ifc.funct = f; ifc.alu_out = a; ifc.shifter_out = s;
    ifc.hi_in = h; ifc.lo_in = l; ifc.hilo_busy = busy; ifc.out_ready = ordy;
  endtask

  logic [5:0] codes [14] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                             6'b000000, 6'b000010, 6'b000011, 6'b010000, 6'b010010,
                             6'b111111, 6'b000001, 6'b011000, 6'b100111};

  initial begin
    drive(0, '0, '0, '0, '0, '0, 0, 0);
    ifc64.in_valid = 0; ifc64.funct = '0; ifc64.alu_out = '0; ifc64.shifter_out = '0;
    ifc64.hi_in = '0; ifc64.lo_in = '0; ifc64.hilo_busy = 0; ifc64.out_ready = 1;

    // Reset state
    #12;
    chk("rst_out_valid", {63'b0, ifc.out_valid}, 64'd0);
    chk("rst_data_out", {32'b0, ifc.data_out}, 64'd0);
    chk("rst_out_funct", {58'b0, ifc.out_funct}, 64'd0);
    chk("rst_illegal", {63'b0, ifc.illegal}, 64'd0);
    chk("rst_in_ready", {63'b0, ifc.in_ready}, 64'd1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Back-to-back ADD then SRL
    drive(1, 6'b100000, 32'h5, 32'h0, 32'h0, 32'h0, 0, 1); cycle();
    chk("b2b_add", {32'b0, ifc.data_out}, 64'h5);
    drive(1, 6'b000010, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 0, 1); cycle();
    chk("b2b_srl", {32'b0, ifc.data_out}, 64'h8000_0000);
    chk("b2b_funct", {58'b0, ifc.out_funct}, 64'b000010);
    drive(0, '0, '0, '0, '0, '0, 0, 1); cycle();

    // Backpressure: OR held while SUB waits
    drive(1, 6'b100101, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 0, 1); cycle();
    drive(1, 6'b100010, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", {32'b0, ifc.data_out}, 64'hFFFF_0000);
    end
    ifc.out_ready = 1; cycle();
    chk("bp_sub", {32'b0, ifc.data_out}, 64'h77);
    drive(0, '0, '0, '0, '0, '0, 0, 1); cycle();

    // HI/LO stall: busy values of hi_in must never be output
    drive(1, 6'b010000, 32'h0, 32'h0, $urandom, 32'h0, 1, 1); cycle();
    ifc.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      ifc.hi_in = $urandom; cycle();
    end
    ifc.hilo_busy = 0; ifc.hi_in = 32'h1234_5678; cycle();
    chk("stall_hi", {32'b0, ifc.data_out}, 64'h1234_5678);
    ifc.hi_in = 32'h0; cycle();

    // Illegal funct, then AND clears it
    drive(1, 6'b111111, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0, 1); cycle();
    chk("ill_flag", {63'b0, ifc.illegal}, 64'd1);
    chk("ill_data", {32'b0, ifc.data_out}, 64'd0);
    drive(1, 6'b100100, 32'h0000_00A5, 32'h0, 32'h0, 32'h0, 0, 1); cycle();
    chk("ill_clear", {63'b0, ifc.illegal}, 64'd0);

    // Asynchronous reset while waiting on HI/LO
    drive(1, 6'b010010, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1); cycle();
    ifc.in_valid = 0; #2;
    rst_n = 0; #1;
    chk("arst_out_valid", {63'b0, ifc.out_valid}, 64'd0);
    chk("arst_data_out", {32'b0, ifc.data_out}, 64'd0);
    chk("arst_in_ready", {63'b0, ifc.in_ready}, 64'd1);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("arst_rel_ready", {63'b0, ifc.in_ready}, 64'd1);

    // 64-bit instance: MFLO passes the full width
    ifc64.in_valid = 1; ifc64.funct = 6'b010010; ifc64.lo_in = 64'hFFFF_FFFF_0000_0001;
    @(posedge clk); #1;
    ifc64.in_valid = 0;
    chk("w64_valid", {63'b0, ifc64.out_valid}, 64'd1);
    chk("w64_data", ifc64.data_out, 64'hFFFF_FFFF_0000_0001);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 13)], $urandom, $urandom,
            $urandom, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result-select and handoff stage for the MIPS ALU datapath, generalised from the combinational funct-decoded result mux. It picks the result from the ALU, shifter, or HI/LO unit using the R-type funct field, and presents it on a valid/ready output with one-cycle latency. An MFHI/MFLO issued while the multiply/divide unit is still busy is held until HI/LO are final. Unrecognised funct codes produce zero and raise a per-result illegal flag.

## Interface
Parameters:
- WIDTH, 32, datapath width of all data inputs and `data_out`.
- FUNCT_W, 6, width of the funct field; all funct encodings below are FUNCT_W-bit values.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage accepts the operation this cycle.
- funct  input  FUNCT_W  operation select.
- alu_out  input  WIDTH  ALU result.
- shifter_out  input  WIDTH  shifter result.
- hi_in  input  WIDTH  HI register value.
- lo_in  input  WIDTH  LO register value.
- hilo_busy  input  1  multiply/divide in progress; HI/LO not final.
- out_valid  output  1  `data_out` holds a result.
- out_ready  input  1  downstream consumes the result.
- data_out  output  WIDTH  selected result.
- out_funct  output  FUNCT_W  funct of the result in `data_out`.
- illegal  output  1  result came from an unrecognised funct.

## Operation
Funct decode:
- AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 → `alu_out`.
- SLL 000000, SRL 000010, SRA 000011 → `shifter_out`.
- MFHI 010000 → `hi_in`; MFLO 010010 → `lo_in`.
- Any other code → 0, with `illegal`=1.

State machine (states EMPTY, FULL, WAIT_HILO):
- **EMPTY**: `out_valid`=0, `in_ready`=1.
  - Accept with a non-HI/LO op, or with MFHI/MFLO while `hilo_busy`=0 → register result, go FULL.
  - Accept MFHI/MFLO while `hilo_busy`=1 → latch `funct` into `out_funct`, go WAIT_HILO.
- **FULL**: `out_valid`=1; `in_ready`=`out_ready`.
  - `out_ready`=1 with no accept → EMPTY.
  - `out_ready`=1 with accept → load the new op. Target is FULL, or WAIT_HILO per the EMPTY rules.
  - `out_ready`=0 → hold `data_out`, `out_funct` and `illegal` stable.
- **WAIT_HILO**: `out_valid`=0, `in_ready`=0.
  - Each cycle, sample `hilo_busy`. When it is 0, register `hi_in` or `lo_in` (per the latched funct) and go FULL.

Rules:
- HI/LO are sampled in the same cycle `hilo_busy` is observed low; the cycle in which busy is high is never used.
- `in_valid`=1 with `in_ready`=0 is not an accept; upstream must hold `funct` and its data.
- No arithmetic is performed; data passes through at full WIDTH.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): state EMPTY, `out_valid`=0, `data_out`=0, `out_funct`=0, `illegal`=0, `in_ready`=1.
- Reset mid-WAIT_HILO or mid-FULL discards the pending result.
- Latency: an accept at edge N gives `out_valid`=1 after edge N. For HI/LO ops delayed by busy, `out_valid`=1 after the first edge where `hilo_busy`=0.
- Throughput: one result per cycle when `out_ready` is held at 1 and no HI/LO stall occurs.
- `in_ready` is combinational from state and `out_ready` only. It has no path from `in_valid` or `funct`.
- `out_valid`, `data_out`, `out_funct` and `illegal` are registered outputs with no combinational input paths.

## Test plan
- **Reset and back-to-back ops.** After reset, check all outputs are 0 and `in_ready`=1. Issue ADD with `alu_out`=0x0000_0005, then SRL with `shifter_out`=0x8000_0000, with `out_ready`=1. Required: consecutive cycles show `data_out` 0x5 then 0x8000_0000, `out_funct` 100000 then 000010, `illegal`=0.
- **Backpressure.** Issue OR (result 0xFFFF_0000) with `out_ready`=0 for 3 cycles, while `in_valid` stays high with a SUB. Required: `in_ready`=0 and `data_out` held at 0xFFFF_0000 throughout. When `out_ready` rises, the SUB result appears on the next cycle.
- **HI/LO stall.** Issue MFHI with `hilo_busy`=1 for 4 cycles, then drop busy with `hi_in`=0x1234_5678. Required: `in_ready`=0 and `out_valid`=0 during the stall. `data_out`=0x1234_5678 appears one cycle after busy falls, and the `hi_in` value present while busy was high is never output.
- **Illegal funct.** Issue funct 111111 with `alu_out`=0xDEAD_BEEF. Required: `data_out`=0, `illegal`=1, `out_funct`=111111. A following AND clears `illegal`.
- **Asynchronous reset.** Assert `rst_n` low mid-cycle while in WAIT_HILO. Required: `out_valid` and `data_out` clear immediately, not waiting for a clock edge. After release, `in_ready`=1.
- **Width parameter.** Instantiate with WIDTH=64 and issue MFLO with `lo_in`=0xFFFF_FFFF_0000_0001, `hilo_busy`=0. Required: that full 64-bit value is output.
